div_freq_meter: RTL and testbench
=================================

# div_freq_meter

Measures the rate of one selected divided-clock tap, such as the ripple divider outputs clk/2 through clk/16, by counting its rising edges over a fixed window of system-clock cycles. It sits directly downstream of the clock divider. Each tap is synchronised into the `clk` domain and edge-detected, and the edge count is returned through a valid/ready result port. It serves self-test and rate checking of divider outputs.

## Interface
Parameters:
- `NUM_TAPS`, default 4: number of tap inputs.
- `GATE_CYCLES`, default 256: measurement window length in `clk` cycles; must be ≥1.
- `CNT_W`, default 16: width of the result counter.
- `SYNC_STAGES`, default 2: flip-flop stages in each tap synchroniser; must be ≥2.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous active-low reset (0 = in reset).
- `taps`  in  `NUM_TAPS`  divided-clock inputs, asynchronous to `clk`.
- `sel`  in  `$clog2(NUM_TAPS)`  tap index; latched on an accepted `start`.
- `start`  in  1  single-cycle request; honoured only in IDLE.
- `busy`  out  1  high in ARM, GATE and HOLD.
- `result`  out  `CNT_W`  edge count; stable while `result_valid` is high.
- `result_valid`  out  1  result available.
- `result_ready`  in  1  consumer accepts the result.
- `overflow`  out  1  count saturated during the window; qualified by `result_valid`.

## Operation
- FSM states:
  - IDLE
    - `start` → ARM.
    - Latches `sel`, clears the counter and `overflow`.
  - ARM
    - Waits `SYNC_STAGES`+1 cycles to flush stale synchroniser and edge history, then → GATE.
    - Edges in ARM are not counted.
  - GATE
    - Runs exactly `GATE_CYCLES` cycles.
    - Each detected rising edge of the latched tap adds 1 to the counter.
    - After the last cycle → HOLD.
  - HOLD
    - `result_valid`=1.
    - Transfer occurs on `result_valid` && `result_ready` → IDLE.
- Edge detection: synchronised tap is high this cycle and was low last cycle.
- Every tap is synchronised continuously. Only the latched tap is counted.
- Counter arithmetic:
  - Unsigned `CNT_W`, saturating at 2^`CNT_W`−1.
  - An edge arriving at the saturation value sets `overflow`. `overflow` stays set until the next accepted `start`.
- Boundary conditions:
  - `start` outside IDLE is ignored; no queueing.
  - A `sel` change after `start` has no effect until the next measurement.
  - `sel` ≥ `NUM_TAPS` selects tap 0.
  - `start` and `result_ready` high in the same cycle in HOLD: the transfer completes; `start` is ignored.
  - Reset asserted mid-measurement: immediate return to IDLE, all outputs at reset values, and the partial count discarded.
- Input constraint: each tap must be high ≥1 and low ≥1 `clk` period. A clk/2 tap toggling every `clk` cycle is therefore the fastest measurable input.

## Timing
- Reset values: `busy`=0, `result`=0, `result_valid`=0, `overflow`=0; state IDLE; synchronisers all 0.
- Latency from `start` to `busy`=1: 1 cycle.
- ARM lasts `SYNC_STAGES`+1 cycles. GATE lasts `GATE_CYCLES` cycles.
- `result_valid` rises the cycle after the final GATE cycle.
- Latency from a tap edge to the counter increment: `SYNC_STAGES`+1 cycles.
- `result` and `overflow` are registered and held constant throughout HOLD.
- `busy` falls the cycle after the transfer.

## Configuration
- `DIV_FREQ_METER_CONTINUOUS_EN` defined:
  - After a HOLD transfer the FSM goes straight to ARM, re-using the latched `sel`.
  - `start` is still required for the first measurement.
  - `start` with `sel` change takes effect only from IDLE, i.e. after reset.
- `DIV_FREQ_METER_CONTINUOUS_EN` undefined: single-shot behaviour as specified above.

## Structure
- Package `div_freq_meter_pkg` holds:
  - the FSM state enum (IDLE, ARM, GATE, HOLD);
  - the `ARM` length constant expression;
  - the gate counter width function, `$clog2(GATE_CYCLES+1)`.
- Sub-module `tap_sync_edge`: one instance per tap. It contains a `SYNC_STAGES` flip-flop chain and a previous-value register, with outputs `sync` and `rise`. It uses the same async active-low reset.

## Test plan
- Tap 3 is clk/8 (toggling every 4 cycles), `sel`=3, `GATE_CYCLES`=256, `start` → `result`=32 ±1, `overflow`=0, `result_valid` at `start`+1+3+256 cycles.
- Tap 0 is clk/2, `CNT_W`=4 → `result`=15, `overflow`=1.
- Backpressure: hold `result_ready` low for 10 cycles in HOLD → `result` and `result_valid` stable. Raise `result_ready` → IDLE next cycle, `busy`=0.
- Change `sel` 1→2 and pulse `start` again during GATE → count matches tap 1; second `start` ignored.
- Assert `reset` low at cycle 100 of GATE → all outputs 0 immediately. A new `start` after release produces a full-window result.
- Continuous build: `start` once, accept 3 results with `result_ready` tied high → three results of 32, `busy` never falls.

Source files
------------

// File: rtl/div_freq_meter_pkg.sv
// Shared types and sizing helpers for the divided-clock rate meter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_freq_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_GATE = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // Cycles spent flushing synchroniser and edge history before counting.
    function automatic int arm_cycles(input int sync_stages);
        return sync_stages + 1;
    endfunction

    function automatic int gate_cnt_w(input int gate_cycles);
        return $clog2(gate_cycles + 1);
    endfunction

endpackage

// File: rtl/div_freq_meter_tap_sync_edge.sv
// Synchronises one asynchronous divider tap into clk and flags its rising edges.
// Latency: sync follows tap after SYNC_STAGES cycles; rise is combinational from registers.
// Backpressure: none, free-running.
module tap_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic tap,
    output logic sync,
    output logic rise
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], tap};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign sync = chain[SYNC_STAGES-1];
    assign rise = sync & ~prev;

endmodule

// File: rtl/div_freq_meter.sv
// Counts rising edges of one selected divider tap over GATE_CYCLES clk cycles; DIV_FREQ_METER_CONTINUOUS_EN re-arms after each result.
// Latency: busy 1 cycle after start; result_valid SYNC_STAGES+1+GATE_CYCLES cycles after busy rises.
// Backpressure: result/overflow held in HOLD until result_ready; start ignored outside IDLE.
module div_freq_meter
    import div_freq_meter_pkg::*;
#(
    parameter int  NUM_TAPS    = 4,
    parameter int  GATE_CYCLES = 256,
    parameter int  CNT_W       = 16,
    parameter int  SYNC_STAGES = 2,
    localparam int SEL_W       = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_TAPS-1:0] taps,
    input  logic [SEL_W-1:0]    sel,
    input  logic                start,
    output logic                busy,
    output logic [CNT_W-1:0]    result,
    output logic                result_valid,
    input  logic                result_ready,
    output logic                overflow
);

    localparam int ARM_LEN = arm_cycles(SYNC_STAGES);
    localparam int GATE_W  = gate_cnt_w(GATE_CYCLES);
    localparam int ARM_W   = $clog2(ARM_LEN + 1);
    localparam int TMR_W   = (GATE_W > ARM_W) ? GATE_W : ARM_W;

    localparam logic [TMR_W-1:0] ARM_LAST  = TMR_W'(ARM_LEN - 1);
    localparam logic [TMR_W-1:0] GATE_LAST = TMR_W'(GATE_CYCLES - 1);
    localparam logic [SEL_W:0]   SEL_LIM   = (SEL_W + 1)'(NUM_TAPS);

    state_t              state;
    state_t              state_nxt;
    logic [TMR_W-1:0]    tmr;
    logic [NUM_TAPS-1:0] tap_sync;
    logic [NUM_TAPS-1:0] tap_rise;
    logic [SEL_W-1:0]    sel_q;
    logic [SEL_W-1:0]    sel_clamp;
    logic [CNT_W-1:0]    cnt;
    logic                ovf;
    logic                start_acc;
    logic                cnt_clr;
    logic                cnt_en;

    for (genvar i = 0; i < NUM_TAPS; i++) begin : g_tap
        tap_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk   (clk),
            .reset (reset),
            .tap   (taps[i]),
            .sync  (tap_sync[i]),
            .rise  (tap_rise[i])
        );
    end

    // Out-of-range selects fall back to tap 0.
    assign sel_clamp = ({1'b0, sel} >= SEL_LIM) ? '0 : sel;

    assign cnt_en = (state == ST_GATE) && tap_rise[sel_q] && tap_sync[sel_q];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        cnt_clr   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_ARM;
                    start_acc = 1'b1;
                    cnt_clr   = 1'b1;
                end
            end
            ST_ARM: begin
                if (tmr == ARM_LAST) begin
                    state_nxt = ST_GATE;
                end
            end
            ST_GATE: begin
                if (tmr == GATE_LAST) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (result_ready) begin
`ifdef DIV_FREQ_METER_CONTINUOUS_EN
                    state_nxt = ST_ARM;
                    cnt_clr   = 1'b1;
`else
                    state_nxt = ST_IDLE;
`endif
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Phase timer restarts on every state change and only runs in ARM and GATE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmr <= '0;
        end else if (state_nxt != state) begin
            tmr <= '0;
        end else if (state == ST_ARM || state == ST_GATE) begin
            tmr <= tmr + TMR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_q <= '0;
        end else if (start_acc) begin
            sel_q <= sel_clamp;
        end
    end

    // Saturating edge counter; an edge landing on the ceiling marks overflow instead.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (cnt_clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (cnt_en) begin
            if (&cnt) begin
                ovf <= 1'b1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign busy         = (state != ST_IDLE);
    assign result_valid = (state == ST_HOLD);
    assign result       = cnt;
    assign overflow     = ovf;

endmodule

// File: tb/tb_div_freq_meter.sv
// Randomised bench for div_freq_meter: two instances (16-bit/4 taps and 4-bit/3 taps) share all inputs.
// A window-counting model predicts busy, result_valid, result and overflow every cycle.
module tb_div_freq_meter;

    localparam int NT   = 4;
    localparam int NT_S = 3;
    localparam int G    = 256;
    localparam int S    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  taps;
    logic [1:0]  sel;
    logic        start;
    logic        result_ready;

    logic        busy, result_valid, overflow;
    logic [15:0] result;
    logic        s_busy, s_valid, s_overflow;
    logic [3:0]  s_result;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    bit [3:0] hist [0:65535];

    bit m_busy, m_valid, m_ovf, m_sovf;
    int m_e0, m_sel, m_ssel, m_res, m_sres;

    int ph   = 0;
    int run1 = 1;
    int run2 = 12;

    always #5 clk = ~clk;

    div_freq_meter #(
        .NUM_TAPS (NT), .GATE_CYCLES (G), .CNT_W (16), .SYNC_STAGES (S)
    ) dut (
        .clk (clk), .reset (reset), .taps (taps), .sel (sel), .start (start),
        .busy (busy), .result (result), .result_valid (result_valid),
        .result_ready (result_ready), .overflow (overflow)
    );

    div_freq_meter #(
        .NUM_TAPS (NT_S), .GATE_CYCLES (G), .CNT_W (4), .SYNC_STAGES (S)
    ) dut_sat (
        .clk (clk), .reset (reset), .taps (taps[2:0]), .sel (sel), .start (start),
        .busy (s_busy), .result (s_result), .result_valid (s_valid),
        .result_ready (result_ready), .overflow (s_overflow)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Tap 0 = clk/2, tap 3 = clk/8, taps 1/2 random run lengths (fast / slow).
    initial begin
        taps = '0;
        forever begin
            @(negedge clk);
            ph++;
            taps[0] = ~taps[0];
            if (ph % 4 == 0) taps[3] = ~taps[3];
            run1--;
            if (run1 == 0) begin
                taps[1] = ~taps[1];
                run1 = $urandom_range(1, 5);
            end
            run2--;
            if (run2 == 0) begin
                taps[2] = ~taps[2];
                run2 = $urandom_range(10, 30);
            end
        end
    end

    // Rising edge sampled at edge k is counted iff edge k+S lies inside the gate window.
    function automatic int count_rises(input int e0, input int tap);
        int n = 0;
        for (int k = e0 + 2; k <= e0 + G + 1; k++) begin
            if (hist[k][tap] && !hist[k-1][tap]) n++;
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_res   = 0;
            m_ovf   = 1'b0;
            m_sres  = 0;
            m_sovf  = 1'b0;
        end else begin
            cyc++;
            hist[cyc] = taps;
            if (m_valid && result_ready) begin
                m_valid = 1'b0;
`ifdef DIV_FREQ_METER_CONTINUOUS_EN
                m_e0 = cyc;
`else
                m_busy = 1'b0;
`endif
            end else if (!m_busy && start) begin
                m_busy = 1'b1;
                m_e0   = cyc;
                m_sel  = int'(sel);
                m_ssel = (int'(sel) < NT_S) ? int'(sel) : 0;
            end else if (m_busy && !m_valid && cyc == m_e0 + S + 1 + G) begin
                int n, ns;
                m_valid = 1'b1;
                n       = count_rises(m_e0, m_sel);
                ns      = count_rises(m_e0, m_ssel);
                m_res   = (n > 65535) ? 65535 : n;
                m_ovf   = (n > 65535);
                m_sres  = (ns > 15) ? 15 : ns;
                m_sovf  = (ns > 15);
            end
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            chk("busy", busy, m_busy);
            chk("valid", result_valid, m_valid);
            chk("sat_busy", s_busy, m_busy);
            chk("sat_valid", s_valid, m_valid);
            if (m_valid) begin
                chk("result", result, m_res);
                chk("overflow", overflow, m_ovf);
                chk("sat_result", s_result, m_sres);
                chk("sat_overflow", s_overflow, m_sovf);
            end
        end
    end

    task automatic do_start(input int s, output int st);
        sel   = 2'(s);
        start = 1'b1;
        st    = cyc;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (result_valid === 1'b1) begin
                ok = 1'b1;
                return;
            end
            tick(1);
        end
        chk("valid_timeout", 0, 1);
    endtask

    task automatic accept();
        result_ready = 1'b1;
        tick(1);
        result_ready = 1'b0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_result"}, result, 0);
        chk({nm, "_valid"}, result_valid, 0);
        chk({nm, "_overflow"}, overflow, 0);
        chk({nm, "_sat_busy"}, s_busy, 0);
        chk({nm, "_sat_result"}, s_result, 0);
        chk({nm, "_sat_valid"}, s_valid, 0);
        chk({nm, "_sat_overflow"}, s_overflow, 0);
    endtask

    initial begin
        bit ok;
        int st;
        int last;
        reset        = 1'b0;
        start        = 1'b0;
        sel          = 2'd0;
        result_ready = 1'b0;
        @(negedge clk);
        chk_all_zero("reset");
        tick(2);
        reset = 1'b1;
        tick(4);
`ifdef DIV_FREQ_METER_CONTINUOUS_EN
        do_start(3, st);
        result_ready = 1'b1;
        last = st;
        for (int r = 0; r < 3; r++) begin
            wait_valid(ok);
            chk("cont_latency", cyc - last, 260);
            chk("cont_result", result, 32);
            chk("cont_sat_result", s_result, 15);
            chk("cont_sat_overflow", s_overflow, 1);
            last = cyc;
            tick(1);
            chk("cont_busy", busy, 1);
        end
        result_ready = 1'b0;
        tick(5);
`else
        // clk/8 tap, then hold off the consumer for 10 cycles.
        do_start(3, st);
        wait_valid(ok);
        chk("A_latency", cyc - st, 260);
        chk("A_result", result, 32);
        chk("A_overflow", overflow, 0);
        chk("A_sat_clamp_result", s_result, 15);
        chk("A_sat_clamp_overflow", s_overflow, 1);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("bp_valid", result_valid, 1);
            chk("bp_result", result, 32);
        end
        accept();
        chk("A_busy_after", busy, 0);
        chk("A_valid_after", result_valid, 0);
        tick(3);

        // clk/2 tap: 128 edges, saturating in the 4-bit instance.
        do_start(0, st);
        wait_valid(ok);
        chk("B_result", result, 128);
        chk("B_overflow", overflow, 0);
        chk("B_sat_result", s_result, 15);
        chk("B_sat_overflow", s_overflow, 1);
        accept();
        tick(3);

        // sel change and a second start during GATE are both ignored.
        do_start(1, st);
        tick(50);
        sel   = 2'd2;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_valid(ok);
        accept();
        tick(2);
        chk("C_no_queue", busy, 0);

        // Reset around GATE cycle 100, then a full fresh measurement.
        do_start(2, st);
        tick(103);
        reset = 1'b0;
        #1;
        chk_all_zero("midreset");
        tick(3);
        reset = 1'b1;
        tick(4);
        do_start(3, st);
        wait_valid(ok);
        chk("D_latency", cyc - st, 260);
        chk("D_result", result, 32);
        accept();
        tick(3);

        // Random selects, start spam while busy, random consumer delay, start coincident with transfer.
        for (int it = 0; it < 8; it++) begin
            do_start($urandom_range(0, 3), st);
            repeat ($urandom_range(0, 200)) begin
                start = ($urandom_range(0, 7) == 0);
                sel   = 2'($urandom_range(0, 3));
                tick(1);
            end
            start = 1'b0;
            wait_valid(ok);
            tick($urandom_range(0, 5));
            result_ready = 1'b1;
            start        = ($urandom_range(0, 1) == 1);
            tick(1);
            result_ready = 1'b0;
            start        = 1'b0;
            chk("E_idle_after", busy, 0);
            tick($urandom_range(1, 4));
        end
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
